instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Drives the instruction-load side of the datapath. Holds the program counter, fetches 16-bit instruction words from instruction memory over a request/acknowledge handshake, and presents each fetched word on `IR` with a one-cycle `IL` strobe to the downstream instruction decode register. The decode register samples on the falling clock edge. This block runs on the rising edge, so `IR` and `IL` are stable half a cycle before they are sampled.

## Interface
- `ADDR_WIDTH`, 8: program counter and memory address width.
- `INSTR_WIDTH`, 16: instruction word width. Fixed at 16 for the current ISA.
- `RESET_PC`, 0: program counter value after reset.
- `ACK_TIMEOUT`, 15: maximum number of cycles to wait for `mem_ack` before declaring a fault. Range 1..255.
- Reset is synchronous and active-high.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `fetch_en`, input, 1: control unit requests the next instruction.
- `halt`, input, 1: block new fetches while high.
- `branch_valid`, input, 1: redirect the program counter this cycle.
- `branch_target`, input, `ADDR_WIDTH`: new program counter value.
- `mem_req`, output, 1: instruction memory read request.
- `mem_addr`, output, `ADDR_WIDTH`: read address. Registered.
- `mem_ack`, input, 1: memory read data valid this cycle.
- `mem_rdata`, input, `INSTR_WIDTH`: read data.
- `IR`, output, `INSTR_WIDTH`: instruction to load into the decode register.
- `IL`, output, 1: instruction load strobe. One cycle wide.
- `pc`, output, `ADDR_WIDTH`: address of the next instruction to fetch.
- `busy`, output, 1: a fetch is in flight.
- `fault`, output, 1: sticky memory-timeout flag.

## Operation
- **States:** IDLE, WAIT, FAULT.
- **Reset values:**
  - State is IDLE.
  - `pc` = `mem_addr` = `RESET_PC`.
  - `IR` = 0, `IL` = 0, `mem_req` = 0, `busy` = 0, `fault` = 0.
  - Timeout counter = 0.
- **IDLE, priority order:**
  - If `branch_valid`: `pc` ← `branch_target`. No fetch starts this cycle, even if `fetch_en` is high.
  - Else if `fetch_en` and not `halt`: `mem_addr` ← `pc`, `mem_req` ← 1, timeout counter ← 0, go to WAIT.
  - Else: hold.
- **WAIT:** `mem_req` stays high and `mem_addr` stays stable until `mem_ack`. `busy` = 1.
  - On `mem_ack` with no pending redirect:
    - `IR` ← `mem_rdata`, `IL` ← 1.
    - `pc` ← `pc` + 1, modulo 2^`ADDR_WIDTH`; `pc` wraps from all-ones to 0.
    - `mem_req` ← 0, go to IDLE.
  - If `branch_valid` is seen while in WAIT: latch `branch_target` as a pending redirect. A later `branch_valid` in the same WAIT overwrites it.
    - The request stays open until `mem_ack`.
    - On `mem_ack`, the data is discarded: `IL` stays 0 and `IR` holds.
    - `pc` ← pending target, go to IDLE.
  - `branch_valid` in the same cycle as `mem_ack` counts as a redirect: the data is discarded.
  - `halt` and `fetch_en` are ignored in WAIT. An in-flight fetch always completes.
  - Each cycle without `mem_ack`, the counter increments. When the counter reaches `ACK_TIMEOUT` without an ack: `mem_req` ← 0, `fault` ← 1, go to FAULT.
- **FAULT:** terminal until `reset`.
  - No requests, `IL` = 0, `busy` = 0.
  - `pc`, `IR` and `fault` hold.
  - All inputs are ignored.
- **`IR`:** holds its last value whenever `IL` = 0.
- **`IL`:** is never high in two consecutive cycles.
- **`reset` mid-fetch:** abandons the request. `mem_req` drops at the next edge, and a late `mem_ack` is ignored in IDLE.
- **`mem_ack` in IDLE or FAULT:** ignored.

## Timing
- All outputs are registered on the rising edge.
- `fetch_en` sampled at edge N → `mem_req` = 1 and `mem_addr` = `pc` during cycle N+1.
- `mem_ack` sampled at edge K → `IR` valid, `IL` = 1, `pc` incremented and IDLE during cycle K+1.
- `IL` and `IR` are stable across the falling edge mid-cycle K+1, where the decode register samples them.
- Minimum latency is 2 cycles from `fetch_en` to `IL`, with ack in the first request cycle.
- Peak throughput is one instruction per 2 cycles: `fetch_en` held high, ack immediate.
- Timeout: `fault` rises at the edge `ACK_TIMEOUT` cycles after `mem_req` rises.
- A branch issued in IDLE at edge N makes `pc` = target in cycle N+1. The first fetch from the target can start at edge N+1.

## Test plan
- **Reset defaults:** assert `reset` with `RESET_PC` = 0x10 → `pc` = 0x10, `IR` = 0, `IL` = 0, `mem_req` = 0, `fault` = 0.
- **Single fetch:** hold `fetch_en`; memory acks in the first request cycle with 0x1234 at address 0x10.
  - `mem_addr` = 0x10 one cycle after `fetch_en`.
  - `IL` pulses one cycle later with `IR` = 0x1234; `pc` = 0x11.
  - `IR` stays 0x1234 afterwards.
- **Wrap and stream:** with `pc` = 0xFF and `fetch_en` held, fetch data 0xA001 then 0xA002.
  - Addresses issued are 0xFF then 0x00.
  - `IL` pulses every 2nd cycle; `pc` ends at 0x01.
- **Branch in flight:** start a fetch at 0x20; assert `branch_valid` with target 0x40 while `mem_ack` is delayed 3 cycles.
  - No `IL` pulse; `pc` = 0x40.
  - The next fetch issues `mem_addr` = 0x40.
  - Repeat with `branch_valid` coincident with `mem_ack`: same result.
- **Halt vs. branch priority:** `halt` high in IDLE → no `mem_req` for 10 cycles. In-flight fetch + `halt` → fetch completes with `IL`. `branch_valid` + `fetch_en` in the same IDLE cycle → `pc` = target, `mem_req` stays low that cycle.
- **Timeout:** `ACK_TIMEOUT` = 4 and `mem_ack` never arrives.
  - `mem_req` is high for 4 cycles, then 0; `fault` = 1.
  - Later `fetch_en` and `mem_ack` are ignored.
  - `reset` clears `fault` and returns `pc` to `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds the PC, reads instruction words over a req/ack
// handshake and strobes each one into the falling-edge decode register.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int RESET_PC    = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    input  logic                   halt,
    input  logic                   branch_valid,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic                   IL,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   fault
);

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [7:0]            ACK_LIMIT  = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              ack_cnt;
    logic                    redir_pending;
    logic [ADDR_WIDTH-1:0]   redir_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_ADDR;
            mem_addr      <= RESET_ADDR;
            mem_req       <= 1'b0;
            IR            <= '0;
            IL            <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            ack_cnt       <= '0;
            redir_pending <= 1'b0;
            redir_target  <= '0;
        end else begin
            IL <= 1'b0;
            case (state)
                IDLE: begin
                    if (branch_valid) begin
                        pc <= branch_target;
                    end else if (fetch_en && !halt) begin
                        mem_addr      <= pc;
                        mem_req       <= 1'b1;
                        busy          <= 1'b1;
                        ack_cnt       <= '0;
                        redir_pending <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        busy          <= 1'b0;
                        redir_pending <= 1'b0;
                        state         <= IDLE;
                        // A redirect seen during this fetch (or on the ack cycle) discards the word.
                        if (branch_valid) begin
                            pc <= branch_target;
                        end else if (redir_pending) begin
                            pc <= redir_target;
                        end else begin
                            IR <= mem_rdata;
                            IL <= 1'b1;
                            pc <= pc + 1'b1;
                        end
                    end else if (ack_cnt == ACK_LIMIT) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        fault   <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                        if (branch_valid) begin
                            redir_pending <= 1'b1;
                            redir_target  <= branch_target;
                        end
                    end
                end
                FAULT: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
